bufpool_read_seq: RTL and testbench
===================================

// Module: bufpool_read_seq
// PURPOSE
//  Read-side sequencer for the 64-bank buffer pool. Accepts a burst command (base, length), drives
//  the pool's port-B address bus and tracks the pool's fixed read latency. Returns every bank's word
//  as one wide beat on a valid/ready stream toward the MAC mesh.
//  A small skid FIFO absorbs in-flight reads when the consumer stalls.
// PARAMETERS
//  X_MAC       4             kernels per mesh port
//  X_MESH      16            mesh ports
//  ADDR_LEN    13            bank address width; RAM_DEPTH = 2**ADDR_LEN
//  DATA_LEN    32            bank word width
//  RD_LATENCY  2             pool addrb->doutb latency (output-registered BRAM)
//  FIFO_DEPTH  RD_LATENCY+2  skid FIFO entries; must be >= RD_LATENCY+2 for full throughput
//  BUFFER_NUM = X_MAC*X_MESH; DATAWIDTH = BUFFER_NUM*DATA_LEN; ADDRWIDTH = BUFFER_NUM*ADDR_LEN
// PORTS
//  clk        in   1           single clock domain
//  rst        in   1           asynchronous, active-high reset
//  cmd_valid  in   1           burst command present
//  cmd_ready  out  1           high only in IDLE
//  cmd_base   in   ADDR_LEN    first bank address
//  cmd_len    in   ADDR_LEN+1  beats in burst (0..RAM_DEPTH)
//  cmd_stride in   ADDR_LEN    address increment (present only with BUFRD_STRIDE_EN)
//  addrb      out  ADDRWIDTH   to pool port B; the same address is replicated to all BUFFER_NUM slices
//  doutb      in   DATAWIDTH   from pool port B
//  out_data   out  DATAWIDTH   beat to consumer
//  out_valid  out  1           beat present
//  out_ready  in   1           consumer accepts
//  out_last   out  1           final beat of burst
//  busy       out  1           burst not fully delivered
// BEHAVIOUR
//  Reset values: cmd_ready=0 while rst is high, then 1; addrb=0; out_valid=0; out_last=0; busy=0.
//  Reset state: FSM=IDLE, FIFO empty, all latency-pipe valid bits clear.
//  Reset mid-burst: in-flight reads are discarded. Pool data arriving after reset is ignored
//  because the valid pipe has been cleared.
//  FSM:
//  - IDLE: on cmd_valid&cmd_ready, latch base/len.
//    - len==0: accept as no-op and stay in IDLE; no beat is produced.
//    - otherwise: go to ISSUE.
//  - ISSUE: each cycle with credit, drive addrb=cur_addr, push 1 into the valid pipe and advance
//    cur_addr by 1 (or by stride). When the last address is issued, go to DRAIN.
//  - DRAIN: wait until the pipe and FIFO are empty and the last beat has been handshaken, then IDLE.
//  Credit: issue only if (in-flight reads + FIFO occupancy) < FIFO_DEPTH. The FIFO therefore never
//  overflows, and no pool read is ever repeated.
//  Latency: the valid bit for an issue in cycle N reaches the FIFO write at N+RD_LATENCY, capturing
//  doutb. FIFO is first-word-fall-through, so out_valid rises in cycle N+RD_LATENCY.
//  Throughput: with out_ready held at 1, one beat per cycle.
//  Address arithmetic: modulo RAM_DEPTH; the address wraps from RAM_DEPTH-1 to 0 without error.
//  out_last: tagged alongside the final issued read in the pipe and stored in the FIFO with it.
//  Simultaneous FIFO push and pop: allowed; occupancy is unchanged.
//  Stall: out_valid with out_ready=0 holds out_data and out_last stable.
//  New command: accepted only in IDLE, so there is no overlap between bursts.
// CONFIGURATION
//  BUFRD_STRIDE_EN defined: cmd_stride port exists; the address increment is cmd_stride, latched
//  with the command. A stride of 0 re-reads the same address len times.
//  BUFRD_STRIDE_EN undefined: no cmd_stride port; the increment is fixed at 1.
// STRUCTURE
//  Package bufpool_pkg: BUFFER_NUM, DATAWIDTH, ADDRWIDTH derivations and the FSM state enum
//  {IDLE, ISSUE, DRAIN}. The package is shared with the write-side sequencer.
//  Sub-module bufpool_rd_fifo: FWFT skid FIFO with DATAWIDTH+1 bits (data + last) x FIFO_DEPTH,
//  count output used for credit.
//  Top holds the FSM, the address counter, the RD_LATENCY-deep valid/last shift pipe and the addrb
//  replication.
// TESTING
//  Bench model: pool behavioural model with RD_LATENCY=2, bank k word at address a = {k[5:0], a}.
//  1. base=0, len=4, out_ready=1: addrb=0,1,2,3 on consecutive cycles; 4 beats with
//     out_valid from issue+2; out_last on the 4th beat; busy falls after it.
//  2. base=8190, len=4: addrb=8190,8191,0,1; data matches; no stall cycles.
//  3. len=16, out_ready toggling 1-0-0-1: no beat lost or duplicated, FIFO count never exceeds 4,
//     data and out_last stable while stalled, total beats=16.
//  4. len=0 command: cmd accepted in 1 cycle, out_valid never asserts, busy stays 0,
//     next command is accepted immediately.
//  5. rst asserted mid-burst of len=32 at beat 10: outputs reach reset values asynchronously,
//     no out_valid for 3 cycles after release, and a following len=2 burst returns correct data.
//  6. (BUFRD_STRIDE_EN) base=100, len=3, stride=64: addrb=100,164,228; stride=0 gives 100 x3.

Source files
------------

// File: rtl/bufpool_pkg.sv
// Shared buffer-pool definitions: geometry derivations, common types and the
// sequencer FSM state enum. Used by both the read- and write-side sequencers.
package bufpool_pkg;
   localparam int X_MAC      = 4;
   localparam int X_MESH     = 16;
   localparam int ADDR_LEN   = 13;
   localparam int DATA_LEN   = 32;
   localparam int RD_LATENCY = 2;
   localparam int FIFO_DEPTH = RD_LATENCY + 2;
   localparam int RAM_DEPTH  = 2 ** ADDR_LEN;
   localparam int BUFFER_NUM = X_MAC * X_MESH;
   localparam int DATAWIDTH  = BUFFER_NUM * DATA_LEN;
   localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   typedef logic [ADDR_LEN-1:0] addr_t;
   typedef logic [ADDR_LEN:0]   len_t;

   // one skid-FIFO entry: pool word plus end-of-burst tag
   typedef struct packed {
      logic                 last;
      logic [DATAWIDTH-1:0] data;
   } beat_t;

   // every bank slice of port B sees the same address
   function automatic logic [ADDRWIDTH-1:0] replicate_addr(input addr_t a);
      return {BUFFER_NUM{a}};
   endfunction
endpackage

// File: rtl/bufpool_read_seq_if.sv
// Command, pool port-B and output-stream signals of the read sequencer.
// BUFRD_STRIDE_EN adds the cmd_stride field.
interface bufpool_read_seq_if;
   import bufpool_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   addr_t                cmd_base;
   len_t                 cmd_len;
`ifdef BUFRD_STRIDE_EN
   addr_t                cmd_stride;
`endif
   logic [ADDRWIDTH-1:0] addrb;
   logic [DATAWIDTH-1:0] doutb;
   logic [DATAWIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;
   logic                 busy;

   // sequencer side
   modport master (
      input  cmd_valid, cmd_base, cmd_len,
`ifdef BUFRD_STRIDE_EN
      input  cmd_stride,
`endif
      input  doutb, out_ready,
      output cmd_ready, addrb, out_data, out_valid, out_last, busy
   );

   // commander / pool / consumer side
   modport slave (
      output cmd_valid, cmd_base, cmd_len,
`ifdef BUFRD_STRIDE_EN
      output cmd_stride,
`endif
      output doutb, out_ready,
      input  cmd_ready, addrb, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/bufpool_rd_fifo.sv
// First-word-fall-through skid FIFO for pool read beats. Exposes its
// occupancy so the sequencer can ration read issue against free slots.
module bufpool_rd_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  din_i,
   input  logic          pop_i,
   output logic [W-1:0]  dout_o,
   output logic          empty_o,
   output logic [CW-1:0] cnt_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          push_ok, pop_ok;

   assign push_ok = push_i && (cnt_q != CW'(DEPTH));
   assign pop_ok  = pop_i && (cnt_q != '0);

   // storage needs no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din_i;
   end

   // pointers and occupancy; push and pop together leave the count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
         if (pop_ok)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
         if (push_ok && !pop_ok)      cnt_q <= cnt_q + CW'(1);
         else if (pop_ok && !push_ok) cnt_q <= cnt_q - CW'(1);
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
endmodule

// File: rtl/bufpool_read_seq.sv
// Read-side burst sequencer for the 64-bank buffer pool. Issues one port-B
// address per cycle while the skid FIFO has room for everything in flight,
// follows the fixed pool latency with a valid/last shift pipe and streams
// each wide word to the consumer. Macro BUFRD_STRIDE_EN enables a per-command
// address stride; otherwise addresses step by 1.
module bufpool_read_seq
   import bufpool_pkg::*;
(
   input logic                clk,
   input logic                rst,
   bufpool_read_seq_if.master rd
);
   state_t              state_q;
   addr_t               cur_addr_q, addr_q, inc;
   len_t                rem_q;
   logic                cmd_ready_q, busy_q;
   logic [RD_LATENCY:0] vld_pipe, last_pipe;
   logic                credit, issue, hs, out_vld, out_lst;
   logic                fifo_push, fifo_pop, fifo_empty;
   logic [CNT_W-1:0]    fifo_cnt;
   beat_t               fifo_dout;
   int                  occ;

`ifdef BUFRD_STRIDE_EN
   addr_t inc_q;
   // the stride travels with the command and holds for the whole burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                             inc_q <= '0;
      else if (state_q == IDLE && rd.cmd_valid && cmd_ready_q) inc_q <= rd.cmd_stride;
   end
   assign inc = inc_q;
`else
   assign inc = addr_t'(1);
`endif

   // everything issued but not yet handed over must fit in the skid FIFO,
   // so a stalled consumer can never force a dropped or repeated pool read
   always_comb begin
      occ    = $countones(vld_pipe) + int'(fifo_cnt);
      credit = occ < FIFO_DEPTH;
   end
   assign issue = (state_q == ISSUE) && credit;

   // burst FSM: latch the command, walk the address, wait for the last beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         cur_addr_q  <= '0;
         addr_q      <= '0;
         rem_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (rd.cmd_valid && cmd_ready_q) begin
                  cur_addr_q <= rd.cmd_base;
                  rem_q      <= rd.cmd_len;
                  // a zero-length command is consumed without producing beats
                  if (rd.cmd_len != '0) begin
                     state_q     <= ISSUE;
                     cmd_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (issue) begin
                  addr_q     <= cur_addr_q;
                  cur_addr_q <= cur_addr_q + inc;   // wraps modulo RAM_DEPTH
                  rem_q      <= rem_q - len_t'(1);
                  if (rem_q == len_t'(1)) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // beats leave in order, so the tagged one empties pipe and FIFO
               if (hs && out_lst) begin
                  state_q     <= IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // stage 0 marks the address on addrb now; stage RD_LATENCY lines up with doutb
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[RD_LATENCY-1:0], issue};
         last_pipe <= {last_pipe[RD_LATENCY-1:0], issue && (rem_q == len_t'(1))};
      end
   end

   // an arriving word bypasses the FIFO only if it is empty and the consumer takes it
   assign out_vld   = !fifo_empty || vld_pipe[RD_LATENCY];
   assign out_lst   = fifo_empty ? last_pipe[RD_LATENCY] : fifo_dout.last;
   assign hs        = out_vld && rd.out_ready;
   assign fifo_push = vld_pipe[RD_LATENCY] && !(fifo_empty && rd.out_ready);
   assign fifo_pop  = hs && !fifo_empty;

   bufpool_rd_fifo #(.W(DATAWIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   ({last_pipe[RD_LATENCY], rd.doutb}),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .cnt_o   (fifo_cnt)
   );

   assign rd.cmd_ready = cmd_ready_q;
   assign rd.busy      = busy_q;
   assign rd.addrb     = replicate_addr(addr_q);
   assign rd.out_valid = out_vld;
   assign rd.out_last  = out_lst;
   assign rd.out_data  = fifo_empty ? rd.doutb : fifo_dout.data;
endmodule

// File: tb/tb_bufpool_read_seq.sv
// Bench for bufpool_read_seq: 2-cycle pool model, queue scoreboard of expected
// beat addresses checked every cycle, plus literal timing pins per scenario.
module tb_bufpool_read_seq;
   import bufpool_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bufpool_read_seq_if bus();

   bufpool_read_seq dut (
      .clk (clk),
      .rst (rst),
      .rd  (bus)
   );

   int vectors = 0;
   int errors  = 0;
   int beats   = 0;
   int cyc     = 0;
   int mode    = 0;   // out_ready policy: 0 always, 1 pattern 1-0-0-1, 2 random
   int cur_stride = 1;

   // pool: bank k at address a holds {k[5:0], a}; addrb->doutb is 2 cycles
   function automatic logic [DATAWIDTH-1:0] pool_read(input logic [ADDRWIDTH-1:0] a);
      logic [DATAWIDTH-1:0] d;
      d = '0;
      for (int k = 0; k < BUFFER_NUM; k++) begin
         logic [5:0] kb;
         kb = k[5:0];
         d[k*DATA_LEN +: DATA_LEN] = DATA_LEN'({kb, a[k*ADDR_LEN +: ADDR_LEN]});
      end
      return d;
   endfunction

   function automatic logic [DATAWIDTH-1:0] exp_beat(input addr_t a);
      logic [ADDRWIDTH-1:0] rep;
      rep = {BUFFER_NUM{a}};
      return pool_read(rep);
   endfunction

   logic [ADDRWIDTH-1:0] pool_a = '0;
   logic [DATAWIDTH-1:0] pool_d = '0;
   always @(posedge clk) begin
      pool_a <= bus.addrb;
      pool_d <= pool_read(pool_a);
      cyc    <= cyc + 1;
   end
   assign bus.doutb = pool_d;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endfunction

   function automatic void chk_data(input string nm, input logic [DATAWIDTH-1:0] act,
                                    input logic [DATAWIDTH-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         for (int k = 0; k < BUFFER_NUM; k++)
            if (act[k*DATA_LEN +: DATA_LEN] !== exp[k*DATA_LEN +: DATA_LEN]) begin
               $display("FAIL %s: bank %0d got %0h, want %0h", nm, k,
                        act[k*DATA_LEN +: DATA_LEN], exp[k*DATA_LEN +: DATA_LEN]);
               break;
            end
      end
   endfunction

   // ---------------- scoreboard / compare process ----------------
   addr_t                exp_q[$];
   logic                 busy_m = 1'b0, rdy_m = 1'b0;
   logic                 stall_q = 1'b0, stall_last = 1'b0;
   logic [DATAWIDTH-1:0] stall_data = '0;
   int                   m_base, m_len;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst out_valid", 32'(bus.out_valid), 0);
         chk("rst out_last", 32'(bus.out_last), 0);
         chk("rst busy", 32'(bus.busy), 0);
         chk("rst cmd_ready", 32'(bus.cmd_ready), 0);
         chk("rst addrb nonzero", 32'(bus.addrb != '0), 0);
         exp_q.delete();
         busy_m  = 1'b0;
         rdy_m   = 1'b0;
         stall_q = 1'b0;
      end else begin
         chk("cmd_ready", 32'(bus.cmd_ready), 32'(rdy_m));
         chk("busy", 32'(bus.busy), 32'(busy_m));
         chk("fifo count <= 4", 32'(int'(dut.fifo_cnt) <= 4), 1);
         if (stall_q) begin
            chk("stall out_valid", 32'(bus.out_valid), 1);
            chk_data("stall data", bus.out_data, stall_data);
            chk("stall out_last", 32'(bus.out_last), 32'(stall_last));
         end
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL extra beat: out_valid got 1, want 0 (nothing outstanding)");
            end else begin
               chk_data("beat data", bus.out_data, exp_beat(exp_q[0]));
               chk("beat out_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  beats++;
               end
            end
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            m_base = int'(bus.cmd_base);
            m_len  = int'(bus.cmd_len);
            for (int i = 0; i < m_len; i++) exp_q.push_back(addr_t'(m_base + i * cur_stride));
         end
         busy_m     = exp_q.size() != 0;
         rdy_m      = !busy_m;
         stall_q    = bus.out_valid && !bus.out_ready;
         stall_data = bus.out_data;
         stall_last = bus.out_last;
      end
   end

   // ---------------- consumer ready driver ----------------
   initial begin
      int ph;
      ph = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: bus.out_ready = 1'b1;
            1: begin
               bus.out_ready = (ph == 0) || (ph == 3);
               ph = (ph + 1) % 4;
            end
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input int base, input int len, input int stride, output int acc);
      int n;
      n = 0;
      cur_stride   = stride;
      bus.cmd_base = addr_t'(base);
      bus.cmd_len  = len_t'(len);
`ifdef BUFRD_STRIDE_EN
      bus.cmd_stride = addr_t'(stride);
`endif
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cmd accepted", 32'(bus.cmd_ready), 1);
      acc = cyc;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("burst done within budget", 32'(bus.busy), 0);
      @(posedge clk);
      #1;
   endtask

   // out_ready held high: addrb from accept+2, beats from accept+4, busy drops after last
   task automatic burst_timing(input int base, input int len, input int stride);
      int acc;
      send_cmd(base, len, stride, acc);
      for (int j = 1; j <= len + 4; j++) begin
         @(negedge clk);
         if (j >= 2 && j <= len + 1)
            chk("addrb sequence", 32'(bus.addrb[ADDR_LEN-1:0]), 32'((base + (j - 2) * stride) % RAM_DEPTH));
         chk("out_valid timing", 32'(bus.out_valid), 32'(j >= 4 && j <= len + 3));
         chk("out_last timing", 32'(bus.out_last), 32'(j == len + 3));
         chk("busy timing", 32'(bus.busy), 32'(j <= len + 3));
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int acc, acc2, b0, n, len, base;
      bus.cmd_valid = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
`ifdef BUFRD_STRIDE_EN
      bus.cmd_stride = '0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 1: basic burst timing
      mode = 0;
      burst_timing(0, 4, 1);
      // 2: wrap at the top of the address space
      burst_timing(8190, 4, 1);

      // 3: stalling consumer
      mode = 1;
      b0 = beats;
      send_cmd(int'($urandom_range(0, RAM_DEPTH - 1)), 16, 1, acc);
      wait_idle(400);
      chk("len16 total beats", 32'(beats - b0), 16);

      // 4: zero-length command, then immediate acceptance of the next
      mode = 0;
      b0 = beats;
      send_cmd(77, 0, 1, acc);
      send_cmd(300, 3, 1, acc2);
      chk("accept right after len0", 32'(acc2 - acc), 1);
      wait_idle(100);
      chk("len0+len3 beats", 32'(beats - b0), 3);

      // 5: reset in the middle of a long burst
      b0 = beats;
      send_cmd(1000, 32, 1, acc);
      n = 0;
      while ((beats - b0) < 10 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reached beat 10", 32'((beats - b0) >= 10), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(bus.out_valid), 0);
      chk("async rst out_last", 32'(bus.out_last), 0);
      chk("async rst busy", 32'(bus.busy), 0);
      chk("async rst cmd_ready", 32'(bus.cmd_ready), 0);
      chk("async rst addrb nonzero", 32'(bus.addrb != '0), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("post-reset out_valid", 32'(bus.out_valid), 0);
      end
      @(posedge clk);
      #1;
      b0 = beats;
      send_cmd(5, 2, 1, acc);
      wait_idle(100);
      chk("post-reset len2 beats", 32'(beats - b0), 2);

`ifdef BUFRD_STRIDE_EN
      // 6: strided and zero-stride bursts
      mode = 0;
      burst_timing(100, 3, 64);
      burst_timing(100, 3, 0);
`endif

      // randomized bursts with random back-pressure, some near the wrap point
      mode = 2;
      for (int t = 0; t < 12; t++) begin
         len  = int'($urandom_range(1, 40));
         base = (t % 3 == 0) ? RAM_DEPTH - int'($urandom_range(1, 20))
                             : int'($urandom_range(0, RAM_DEPTH - 1));
         b0 = beats;
         send_cmd(base, len, 1, acc);
         wait_idle(2000);
         chk("random burst beats", 32'(beats - b0), 32'(len));
      end

      mode = 0;
      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached, got no summary, want summary");
      $fatal(1, "watchdog");
   end
endmodule
